// File: rtl/jal_redirect_ctrl_pkg.sv
// ============================================================================
// Module : jal_redirect_ctrl_pkg
// Brief  : Shared types for the front-end redirect controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package jal_redirect_ctrl_pkg;

  localparam int ADDR_W_DEFAULT = 40;

  // Numeric order is the priority order: a larger code is an older redirect.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DEC  = 2'd1,
    SRC_EXE  = 2'd2,
    SRC_EXC  = 2'd3
  } redir_src_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_SQUASH = 2'd2
  } redir_state_e;

endpackage : jal_redirect_ctrl_pkg

`default_nettype wire

// File: rtl/jal_redirect_ctrl_redir_prio_arb.sv
// ============================================================================
// Module : redir_prio_arb
// Brief  : Fixed-priority select of exception/execute/decode redirects with
//          decode-target alignment masking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module redir_prio_arb
  import jal_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int INST_ALIGN_BITS = 2
) (
  input  logic              dec_jal_valid,
  input  logic [ADDR_W-1:0] dec_jal_target,
  input  logic              exe_redir_valid,
  input  logic [ADDR_W-1:0] exe_redir_target,
  input  logic              exc_redir_valid,
  input  logic [ADDR_W-1:0] exc_redir_target,
  output redir_src_e        win_src,
  output logic [ADDR_W-1:0] win_target,
  output logic              dec_misalign
);

  logic w_low_bits_set;

  generate
    if (INST_ALIGN_BITS > 0) begin : g_align_chk
      assign w_low_bits_set = |dec_jal_target[INST_ALIGN_BITS-1:0];
    end else begin : g_no_align_chk
      assign w_low_bits_set = 1'b0;
    end
  endgenerate

  assign dec_misalign = dec_jal_valid & w_low_bits_set;

  always_comb begin
    win_src    = SRC_NONE;
    win_target = '0;
    if (exc_redir_valid) begin
      win_src    = SRC_EXC;
      win_target = exc_redir_target;
    end else if (exe_redir_valid) begin
      win_src    = SRC_EXE;
      win_target = exe_redir_target;
    end else if (dec_jal_valid && !w_low_bits_set) begin
      win_src    = SRC_DEC;
      win_target = dec_jal_target;
    end
  end

endmodule : redir_prio_arb

`default_nettype wire

// File: rtl/jal_redirect_ctrl.sv
// ============================================================================
// Module : jal_redirect_ctrl
// Brief  : Holds the oldest pending PC redirect for fetch, flushes younger
//          stages and drops wrong-path fetch responses after acceptance.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module jal_redirect_ctrl
  import jal_redirect_ctrl_pkg::*;
#(
  parameter int ADDR_W          = ADDR_W_DEFAULT,
  parameter int SQUASH_CYC      = 2,
  parameter int INST_ALIGN_BITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_jal_valid,
  input  logic [ADDR_W-1:0] dec_jal_target,
  input  logic              exe_redir_valid,
  input  logic [ADDR_W-1:0] exe_redir_target,
  input  logic              exc_redir_valid,
  input  logic [ADDR_W-1:0] exc_redir_target,
  input  logic              if_redir_ready,
  input  logic              if_resp_valid,
  output logic              if_redir_valid,
  output logic [ADDR_W-1:0] if_redir_pc,
  output logic              flush_if,
  output logic              flush_id,
  output logic              resp_drop,
  output logic              dec_stall,
  output logic              jal_misalign,
  output logic [ADDR_W-1:0] jal_misalign_addr
);

  localparam int c_cnt_w = 3;
  localparam logic [c_cnt_w-1:0] c_squash_init = c_cnt_w'(SQUASH_CYC);
  localparam logic [c_cnt_w-1:0] c_cnt_one     = c_cnt_w'(1);

  redir_state_e        r_state;
  redir_src_e          r_src;
  logic [ADDR_W-1:0]   r_target;
  logic [c_cnt_w-1:0]  r_cnt;
  logic                r_redir_valid;
  logic                r_flush_if;
  logic                r_flush_id;
  logic                r_jal_misalign;
  logic [ADDR_W-1:0]   r_jal_misalign_addr;

  redir_src_e          w_win_src;
  logic [ADDR_W-1:0]   w_win_target;
  logic                w_dec_misalign;
  logic                w_load;

  redir_prio_arb #(
    .ADDR_W          (ADDR_W),
    .INST_ALIGN_BITS (INST_ALIGN_BITS)
  ) u_arb (
    .dec_jal_valid    (dec_jal_valid),
    .dec_jal_target   (dec_jal_target),
    .exe_redir_valid  (exe_redir_valid),
    .exe_redir_target (exe_redir_target),
    .exc_redir_valid  (exc_redir_valid),
    .exc_redir_target (exc_redir_target),
    .win_src          (w_win_src),
    .win_target       (w_win_target),
    .dec_misalign     (w_dec_misalign)
  );

  // A load (re)captures the target; in HOLD it must outrank the held source,
  // in SQUASH only execute/exception may cut the drop window short.
  always_comb begin
    w_load = 1'b0;
    case (r_state)
      ST_IDLE:   w_load = (w_win_src != SRC_NONE);
      ST_HOLD:   w_load = (w_win_src > r_src);
      ST_SQUASH: w_load = (w_win_src >= SRC_EXE);
      default:   w_load = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state             <= ST_IDLE;
      r_src               <= SRC_NONE;
      r_target            <= '0;
      r_cnt               <= '0;
      r_redir_valid       <= 1'b0;
      r_flush_if          <= 1'b0;
      r_flush_id          <= 1'b0;
      r_jal_misalign      <= 1'b0;
      r_jal_misalign_addr <= '0;
    end else begin
      r_flush_if     <= 1'b0;
      r_flush_id     <= 1'b0;
      r_jal_misalign <= w_dec_misalign;
      if (w_dec_misalign) begin
        r_jal_misalign_addr <= dec_jal_target;
      end

      if (w_load) begin
        r_state       <= ST_HOLD;
        r_src         <= w_win_src;
        r_target      <= w_win_target;
        r_cnt         <= '0;
        r_redir_valid <= 1'b1;
        r_flush_if    <= 1'b1;
        r_flush_id    <= (w_win_src >= SRC_EXE);
      end else begin
        case (r_state)
          ST_HOLD: begin
            if (if_redir_ready) begin
              r_state       <= ST_SQUASH;
              r_cnt         <= c_squash_init;
              r_redir_valid <= 1'b0;
            end
          end
          ST_SQUASH: begin
            if (if_resp_valid && (r_cnt != '0)) begin
              r_cnt <= r_cnt - c_cnt_one;
              if (r_cnt == c_cnt_one) begin
                r_state <= ST_IDLE;
                r_src   <= SRC_NONE;
              end
            end
          end
          ST_IDLE: ;
          default: begin
            r_state       <= ST_IDLE;
            r_src         <= SRC_NONE;
            r_redir_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign if_redir_valid    = r_redir_valid;
  assign dec_stall         = r_redir_valid;
  assign if_redir_pc       = r_target;
  assign flush_if          = r_flush_if;
  assign flush_id          = r_flush_id;
  assign jal_misalign      = r_jal_misalign;
  assign jal_misalign_addr = r_jal_misalign_addr;
  assign resp_drop         = (r_state == ST_SQUASH) && (r_cnt != '0) && if_resp_valid;

endmodule : jal_redirect_ctrl

`default_nettype wire

// File: tb/tb_jal_redirect_ctrl.sv
// ============================================================================
// Module : tb_jal_redirect_ctrl
// Brief  : Directed and random stimulus against a behavioural redirect model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jal_redirect_ctrl;

  localparam int AW  = 40;
  localparam int SQ  = 2;
  localparam int IAB = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_jal_valid, exe_redir_valid, exc_redir_valid;
  logic [AW-1:0] dec_jal_target, exe_redir_target, exc_redir_target;
  logic          if_redir_ready, if_resp_valid;
  logic          if_redir_valid, flush_if, flush_id, resp_drop, dec_stall, jal_misalign;
  logic [AW-1:0] if_redir_pc, jal_misalign_addr;

  jal_redirect_ctrl #(
    .ADDR_W          (AW),
    .SQUASH_CYC      (SQ),
    .INST_ALIGN_BITS (IAB)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .dec_jal_valid     (dec_jal_valid),
    .dec_jal_target    (dec_jal_target),
    .exe_redir_valid   (exe_redir_valid),
    .exe_redir_target  (exe_redir_target),
    .exc_redir_valid   (exc_redir_valid),
    .exc_redir_target  (exc_redir_target),
    .if_redir_ready    (if_redir_ready),
    .if_resp_valid     (if_resp_valid),
    .if_redir_valid    (if_redir_valid),
    .if_redir_pc       (if_redir_pc),
    .flush_if          (flush_if),
    .flush_id          (flush_id),
    .resp_drop         (resp_drop),
    .dec_stall         (dec_stall),
    .jal_misalign      (jal_misalign),
    .jal_misalign_addr (jal_misalign_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending redirect (with age rank 1..3), a count of
  // wrong-path responses still to discard, and the last-cycle pulses.
  bit          m_pend;
  int          m_rank;
  logic [AW-1:0] m_pc;
  int          m_drops;
  bit          m_fif, m_fid, m_mis;
  logic [AW-1:0] m_mis_addr;

  task automatic model_reset();
    m_pend = 0; m_rank = 0; m_pc = '0; m_drops = 0;
    m_fif = 0; m_fid = 0; m_mis = 0; m_mis_addr = '0;
  endtask

  task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("if_redir_valid", AW'(if_redir_valid), AW'(m_pend));
    chk("dec_stall",      AW'(dec_stall),      AW'(m_pend));
    chk("if_redir_pc",    if_redir_pc,         m_pc);
    chk("flush_if",       AW'(flush_if),       AW'(m_fif));
    chk("flush_id",       AW'(flush_id),       AW'(m_fid));
    chk("resp_drop",      AW'(resp_drop),      AW'(!m_pend && m_drops > 0 && if_resp_valid));
    chk("jal_misalign",   AW'(jal_misalign),   AW'(m_mis));
    chk("jal_mis_addr",   jal_misalign_addr,   m_mis_addr);
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    int          rank;
    logic [AW-1:0] tgt;
    bit          dec_bad;
    bit          take;
    dec_bad = dec_jal_valid && (dec_jal_target % (1 << IAB)) != 0;
    rank = 0; tgt = '0;
    if (exc_redir_valid)                begin rank = 3; tgt = exc_redir_target; end
    else if (exe_redir_valid)           begin rank = 2; tgt = exe_redir_target; end
    else if (dec_jal_valid && !dec_bad) begin rank = 1; tgt = dec_jal_target;   end

    m_fif = 0; m_fid = 0;
    m_mis = dec_bad;
    if (dec_bad) m_mis_addr = dec_jal_target;

    if (m_pend)         take = rank > m_rank;
    else if (m_drops>0) take = rank >= 2;
    else                take = rank > 0;

    if (take) begin
      m_pend = 1; m_rank = rank; m_pc = tgt; m_drops = 0;
      m_fif = 1; m_fid = (rank >= 2);
    end else if (m_pend) begin
      if (if_redir_ready) begin m_pend = 0; m_drops = SQ; end
    end else if (m_drops > 0 && if_resp_valid) begin
      m_drops--;
    end
  endtask

  task automatic cyc(input logic dv, input logic [AW-1:0] dt,
                     input logic ev, input logic [AW-1:0] et,
                     input logic xv, input logic [AW-1:0] xt,
                     input logic rdy, input logic rv);
    @(negedge clk);
    dec_jal_valid = dv;   dec_jal_target   = dt;
    exe_redir_valid = ev; exe_redir_target = et;
    exc_redir_valid = xv; exc_redir_target = xt;
    if_redir_ready = rdy; if_resp_valid = rv;
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input logic rdy, input logic rv);
    cyc(0, '0, 0, '0, 0, '0, rdy, rv);
  endtask

  function automatic logic [AW-1:0] rnd_addr(input bit aligned);
    logic [AW-1:0] a;
    a = {$urandom, $urandom};
    if (aligned) a[IAB-1:0] = '0;
    return a;
  endfunction

  initial begin
    rst_n = 0;
    dec_jal_valid = 0; exe_redir_valid = 0; exc_redir_valid = 0;
    dec_jal_target = '0; exe_redir_target = '0; exc_redir_target = '0;
    if_redir_ready = 0; if_resp_valid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1;

    // Decode JAL, fetch ready: offered at N+1, then two drops, then idle.
    cyc(1, 40'h1000, 0, '0, 0, '0, 1, 0);
    idle(1, 0);
    chk("dir_pc_1000", if_redir_pc, 40'h1000);
    idle(0, 1); idle(0, 1); idle(0, 1);

    // Same-cycle decode and execute: execute wins, decode dropped.
    cyc(1, 40'h1000, 1, 40'h2000, 0, '0, 0, 0);
    idle(0, 0);
    chk("dir_pc_2000", if_redir_pc, 40'h2000);
    idle(1, 0); idle(0, 1); idle(0, 1);

    // Held decode replaced by exception; later decode ignored.
    cyc(1, 40'h1000, 0, '0, 0, '0, 0, 0);
    idle(0, 0); idle(0, 0); idle(0, 0);
    cyc(0, '0, 0, '0, 1, 40'h80_0000_0000 >> 8, 0, 0);
    cyc(1, 40'h3000, 0, '0, 0, '0, 0, 0);
    chk("dir_pc_exc", if_redir_pc, 40'h0_8000_0000);
    idle(1, 0); idle(0, 1); idle(0, 1);

    // Misaligned decode target.
    cyc(1, 40'h1002, 0, '0, 0, '0, 1, 0);
    idle(0, 0);
    chk("dir_mis_addr", jal_misalign_addr, 40'h1002);
    idle(0, 0);

    // Execute preempts SQUASH with one response left.
    cyc(1, 40'h1000, 0, '0, 0, '0, 0, 0);
    idle(1, 0); idle(0, 1);
    cyc(0, '0, 1, 40'h4000, 0, '0, 0, 0);
    idle(0, 1);
    idle(1, 1); idle(0, 1); idle(0, 1); idle(0, 1);

    // Asynchronous reset in the middle of HOLD.
    cyc(1, 40'h5000, 0, '0, 0, '0, 0, 0);
    idle(0, 0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    dec_jal_valid = 0; if_redir_ready = 0; if_resp_valid = 0;
    @(negedge clk);
    rst_n = 1;
    cyc(1, 40'h1000, 0, '0, 0, '0, 1, 0);
    idle(1, 0);
    idle(0, 1); idle(0, 1); idle(0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 3) == 0), rnd_addr($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), rnd_addr(1),
          ($urandom_range(0, 11) == 0), rnd_addr(1),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_jal_redirect_ctrl

`default_nettype wire
